// File: rtl/health_shield_ctrl.sv
// health_shield_ctrl: two-player health/shield round controller.
// FSM IDLE -> FIGHT -> KO; per-player hit cooldown, blocking against shield,
// saturating 4-bit bars. Optional shield regeneration is compiled in only
// when the macro SHIELD_REGEN_EN is defined.

// Per-player bar state: health, shield, hit cooldown and (optional) regen timer.
module health_shield_player #(
    parameter int HIT_DAMAGE    = 2,
    parameter int BLOCK_COST    = 1,
    parameter int INVULN_CYCLES = 12_500_000,
    parameter int REGEN_PERIOD  = 25_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_reload,   // start pulse: refill bars, clear timers
    input  logic       i_play,     // round is live this cycle
    input  logic       i_hit,
    input  logic       i_block,
    output logic [3:0] o_health,
    output logic [3:0] o_shield
);
    localparam int CDW = (INVULN_CYCLES < 1) ? 1 : $clog2(INVULN_CYCLES + 1);
    localparam logic [CDW-1:0] CD_LOAD = CDW'(INVULN_CYCLES);
    // Damage and cost clamp to the 4-bit range so the subtractions cannot wrap.
    localparam logic [3:0] DMG  = (HIT_DAMAGE > 15) ? 4'd15 : 4'(HIT_DAMAGE);
    localparam logic [3:0] COST = (BLOCK_COST > 15) ? 4'd15 : 4'(BLOCK_COST);

    logic [3:0]     r_health;
    logic [3:0]     r_shield;
    logic [CDW-1:0] r_cd;

    logic       w_accept;
    logic       w_can_block;
    logic [3:0] w_health_dmg;

    assign w_accept     = i_hit && (r_cd == '0);
    assign w_can_block  = i_block && (BLOCK_COST <= 15) && (r_shield >= COST);
    assign w_health_dmg = (r_health > DMG) ? (r_health - DMG) : 4'd0;

`ifdef SHIELD_REGEN_EN
    localparam int RGW = (REGEN_PERIOD < 2) ? 1 : $clog2(REGEN_PERIOD);
    localparam logic [RGW-1:0] RG_LAST = RGW'(REGEN_PERIOD - 1);
    logic [RGW-1:0] r_regen;
`endif

    // Bars and timers; an accepted hit excludes a regen step in the same cycle.
    always_ff @(posedge clk) begin
        if (reset || i_reload) begin
            r_health <= 4'd15;
            r_shield <= 4'd15;
            r_cd     <= '0;
`ifdef SHIELD_REGEN_EN
            r_regen  <= '0;
`endif
        end else if (i_play) begin
            if (w_accept) begin
                r_cd <= CD_LOAD;
                if (w_can_block) r_shield <= r_shield - COST;
                else             r_health <= w_health_dmg;
            end else if (r_cd != '0) begin
                r_cd <= r_cd - CDW'(1);
            end
`ifdef SHIELD_REGEN_EN
            if (i_block || w_accept) begin
                r_regen <= '0;
            end else if (r_shield != 4'd15) begin
                if (r_regen == RG_LAST) begin
                    r_shield <= r_shield + 4'd1;
                    r_regen  <= '0;
                end else begin
                    r_regen <= r_regen + RGW'(1);
                end
            end else begin
                r_regen <= '0;
            end
`endif
        end
    end

    assign o_health = r_health;
    assign o_shield = r_shield;
endmodule

// Top: round FSM plus two player instances (index 0 = p1, index 1 = p2).
module health_shield_ctrl #(
    parameter int HIT_DAMAGE    = 2,
    parameter int BLOCK_COST    = 1,
    parameter int INVULN_CYCLES = 12_500_000,
    parameter int REGEN_PERIOD  = 25_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       hit_on_p1,
    input  logic       hit_on_p2,
    input  logic       p1_block,
    input  logic       p2_block,
    output logic [3:0] p1_health,
    output logic [3:0] p1_shield,
    output logic [3:0] p2_health,
    output logic [3:0] p2_shield,
    output logic       round_active,
    output logic       game_over,
    output logic [1:0] winner
);
    typedef enum logic [1:0] {S_IDLE, S_FIGHT, S_KO} state_t;

    state_t r_state;

    logic [1:0]      w_hit;
    logic [1:0]      w_block;
    logic [1:0]      w_zero;
    logic [1:0][3:0] w_health;
    logic [1:0][3:0] w_shield;
    logic            w_play;

    assign w_hit   = {hit_on_p2, hit_on_p1};
    assign w_block = {p2_block, p1_block};
    assign w_zero  = {w_health[1] == 4'd0, w_health[0] == 4'd0};
    // The cycle a bar shows 0 is spent moving to KO, so no more damage lands.
    assign w_play  = (r_state == S_FIGHT) && !start && (w_zero == 2'b00);

    for (genvar g = 0; g < 2; g++) begin : g_player
        health_shield_player #(
            .HIT_DAMAGE   (HIT_DAMAGE),
            .BLOCK_COST   (BLOCK_COST),
            .INVULN_CYCLES(INVULN_CYCLES),
            .REGEN_PERIOD (REGEN_PERIOD)
        ) u_player (
            .clk     (clk),
            .reset   (reset),
            .i_reload(start),
            .i_play  (w_play),
            .i_hit   (w_hit[g]),
            .i_block (w_block[g]),
            .o_health(w_health[g]),
            .o_shield(w_shield[g])
        );
    end

    // Round FSM with registered status outputs; winner latched on entry to KO.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            round_active <= 1'b0;
            game_over    <= 1'b0;
            winner       <= 2'b00;
        end else if (start) begin
            r_state      <= S_FIGHT;
            round_active <= 1'b1;
            game_over    <= 1'b0;
            winner       <= 2'b00;
        end else if (r_state == S_FIGHT && w_zero != 2'b00) begin
            r_state      <= S_KO;
            round_active <= 1'b0;
            game_over    <= 1'b1;
            // bit1: p2 wins (p1 empty), bit0: p1 wins (p2 empty)
            winner       <= {w_zero[0], w_zero[1]};
        end
    end

    assign p1_health = w_health[0];
    assign p1_shield = w_shield[0];
    assign p2_health = w_health[1];
    assign p2_shield = w_shield[1];
endmodule
